// File: rtl/controller_poller_m_if.sv
// controller_poller_m_if: shared pad bus between the poller and its controllers.
// Clock and latch fan out to every pad; each pad returns its own data line.
interface controller_poller_m_if #(
  parameter int NUM_CONTROLLERS = 2
);
  logic                       controller_clk;
  logic                       controller_latch;
  logic [NUM_CONTROLLERS-1:0] controller_data_B;

  modport master (
    output controller_clk,
    output controller_latch,
    input  controller_data_B
  );

  modport slave (
    input  controller_clk,
    input  controller_latch,
    output controller_data_B
  );
endinterface

// File: rtl/controller_poller_m.sv
// controller_poller_m: polls NES/SNES-style serial pads over a shared clk/latch.
// Define CONTROLLER_POLLER_EDGE_DETECT_EN to build the pressed_out edge detector.
module controller_poller_m #(
  parameter int NUM_CONTROLLERS = 2,
  parameter int NUM_BUTTONS     = 8,
  parameter int CLK_DIV         = 1
) (
  input  logic                                   clk_1,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   auto_en,
  controller_poller_m_if.master                  pad,
  output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] buttons_out,
  output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] pressed_out,
  output logic                                   busy,
  output logic                                   valid
);

  localparam int W  = NUM_CONTROLLERS * NUM_BUTTONS;
  localparam int BW = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BW-1:0] BIT_TC = BW'(NUM_BUTTONS - 1);
  localparam logic [DW-1:0] DIV_TC = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [BW-1:0] bitc;
  logic          phase;
  logic          clk_q;
  logic          latch_q;
  logic [W-1:0]  sr;
  logic [W-1:0]  sr_next;
  logic          div_tc;
  logic          bit_tc;
  logic          load;

  assign pad.controller_clk   = clk_q;
  assign pad.controller_latch = latch_q;

  assign div_tc = (div == DIV_TC);
  assign bit_tc = (bitc == BIT_TC);
  assign load   = (state == SHIFT) && div_tc && phase && bit_tc;

  // First sampled bit ends up at index 0 after NUM_BUTTONS shifts.
  for (genvar c = 0; c < NUM_CONTROLLERS; c++) begin : g_sr
    if (NUM_BUTTONS == 1) begin : g_one
      assign sr_next[c] = ~pad.controller_data_B[c];
    end else begin : g_many
      assign sr_next[c*NUM_BUTTONS +: NUM_BUTTONS] =
        {~pad.controller_data_B[c],
         sr[c*NUM_BUTTONS+1 +: NUM_BUTTONS-1]};
    end
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state       <= IDLE;
      div         <= '0;
      bitc        <= '0;
      phase       <= 1'b0;
      clk_q       <= 1'b0;
      latch_q     <= 1'b0;
      busy        <= 1'b0;
      valid       <= 1'b0;
      sr          <= '0;
      buttons_out <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start || auto_en) begin
            state   <= LATCH;
            latch_q <= 1'b1;
            busy    <= 1'b1;
            div     <= '0;
            phase   <= 1'b0;
          end
        end
        // Latch spans two divider phases so it matches one bit period.
        LATCH: begin
          if (div_tc) begin
            div <= '0;
            if (phase) begin
              state   <= SHIFT;
              latch_q <= 1'b0;
              phase   <= 1'b0;
              bitc    <= '0;
            end else begin
              phase <= 1'b1;
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        SHIFT: begin
          if (div_tc) begin
            div <= '0;
            if (!phase) begin
              phase <= 1'b1;
              clk_q <= 1'b1;
              sr    <= sr_next;
            end else begin
              phase <= 1'b0;
              clk_q <= 1'b0;
              if (bit_tc) begin
                state       <= DONE;
                valid       <= 1'b1;
                buttons_out <= sr;
              end else begin
                bitc <= bitc + BW'(1);
              end
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONTROLLER_POLLER_EDGE_DETECT_EN
  logic [W-1:0] pressed_q;

  always_ff @(posedge clk_1) begin
    if (rst) begin
      pressed_q <= '0;
    end else if (load) begin
      pressed_q <= sr & ~buttons_out;
    end
  end

  assign pressed_out = pressed_q;
`else
  assign pressed_out = '0;
`endif

endmodule

// File: tb/tb_controller_poller_m.sv
// tb_controller_poller_m: directed bench with scoreboard for controller_poller_m.
// Pads are modelled as shift registers loaded by latch, advanced by clk rise.
module tb_controller_poller_m;

`ifdef CONTROLLER_POLLER_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk_1 = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic auto_a = 1'b0;
  logic [15:0] buttons_a, pressed_a;
  logic [63:0] buttons_b, pressed_b;
  logic busy_a, valid_a, busy_b, valid_b;

  always #5 clk_1 = ~clk_1;

  controller_poller_m_if #(.NUM_CONTROLLERS(2)) pad_a ();
  controller_poller_m_if #(.NUM_CONTROLLERS(4)) pad_b ();

  controller_poller_m dut_a (
    .clk_1(clk_1), .rst(rst), .start(start_a), .auto_en(auto_a),
    .pad(pad_a), .buttons_out(buttons_a), .pressed_out(pressed_a),
    .busy(busy_a), .valid(valid_a)
  );

  controller_poller_m #(
    .NUM_CONTROLLERS(4), .NUM_BUTTONS(16), .CLK_DIV(3)
  ) dut_b (
    .clk_1(clk_1), .rst(rst), .start(start_b), .auto_en(1'b0),
    .pad(pad_b), .buttons_out(buttons_b), .pressed_out(pressed_b),
    .busy(busy_b), .valid(valid_b)
  );

  // Pad models
  logic [7:0]  pat_a [2];
  logic [15:0] pat_b [4];
  int idx_a = 0;
  int idx_b = 0;
  logic prev_a_clk = 1'b0;
  logic prev_b_clk = 1'b0;
  logic [1:0] data_a;
  logic [3:0] data_b;

  always @(posedge clk_1) begin
    prev_a_clk <= pad_a.controller_clk;
    if (pad_a.controller_latch) idx_a <= 0;
    else if (pad_a.controller_clk && !prev_a_clk) idx_a <= idx_a + 1;
    prev_b_clk <= pad_b.controller_clk;
    if (pad_b.controller_latch) idx_b <= 0;
    else if (pad_b.controller_clk && !prev_b_clk) idx_b <= idx_b + 1;
  end

  always_comb begin
    data_a = '1;
    data_b = '1;
    for (int c = 0; c < 2; c++)
      if (idx_a < 8) data_a[c] = ~pat_a[c][idx_a];
    for (int c = 0; c < 4; c++)
      if (idx_b < 16) data_b[c] = ~pat_b[c][idx_b];
  end

  assign pad_a.controller_data_B = data_a;
  assign pad_b.controller_data_B = data_b;

  // Strobe counters on pad A
  logic cnt_clr = 1'b0;
  int n_latch = 0;
  int n_pulse = 0;

  always @(posedge clk_1) begin
    if (cnt_clr) begin
      n_latch <= 0;
      n_pulse <= 0;
    end else begin
      if (pad_a.controller_latch) n_latch <= n_latch + 1;
      if (pad_a.controller_clk && !prev_a_clk) n_pulse <= n_pulse + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic [63:0] b;
    logic [63:0] p;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  logic [15:0] prev_a = '0;
  logic [63:0] prev_b = '0;
  int n_valid_a = 0;

  task automatic push_a();
    exp_t e;
    logic [15:0] nb;
    nb = {pat_a[1], pat_a[0]};
    e.b = 64'(nb);
    e.p = EDGE ? 64'(nb & ~prev_a) : 64'd0;
    prev_a = nb;
    q_a.push_back(e);
  endtask

  task automatic push_b();
    exp_t e;
    logic [63:0] nb;
    nb = {pat_b[3], pat_b[2], pat_b[1], pat_b[0]};
    e.b = nb;
    e.p = EDGE ? (nb & ~prev_b) : 64'd0;
    prev_b = nb;
    q_b.push_back(e);
  endtask

  always @(negedge clk_1) begin
    exp_t e;
    if (valid_a) begin
      n_valid_a <= n_valid_a + 1;
      if (q_a.size() == 0) begin
        check("valid_unexpected_a", 64'(valid_a), 64'd0);
      end else begin
        e = q_a.pop_front();
        check("buttons_a", 64'(buttons_a), e.b);
        check("pressed_a", 64'(pressed_a), e.p);
      end
    end
    if (valid_b) begin
      if (q_b.size() == 0) begin
        check("valid_unexpected_b", 64'(valid_b), 64'd0);
      end else begin
        e = q_b.pop_front();
        check("buttons_b", buttons_b, e.b);
        check("pressed_b", pressed_b, e.p);
      end
    end
  end

  task automatic wait_valid(input bit which, output int lat);
    lat = 0;
    do begin
      @(posedge clk_1);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      lat++;
    end while (!(which ? valid_b : valid_a) && lat < 400);
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_buttons"}, 64'(buttons_a), 64'd0);
    check({tag, "_pressed"}, 64'(pressed_a), 64'd0);
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_valid"}, 64'(valid_a), 64'd0);
    check({tag, "_latch"}, 64'(pad_a.controller_latch), 64'd0);
    check({tag, "_cclk"}, 64'(pad_a.controller_clk), 64'd0);
  endtask

  initial begin
    int lat;
    int nv0;
    pat_a[0] = 8'b1111_1110;
    pat_a[1] = 8'b0111_1111;
    pat_b[0] = 16'h1234;
    pat_b[1] = 16'hABCD;
    pat_b[2] = 16'h8001;
    pat_b[3] = 16'h0F5A;

    // Reset state
    repeat (3) @(posedge clk_1);
    #1;
    check_zero_a("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk_1);
    #1;

    // Single poll: latency, result and strobe shape
    cnt_clr = 1'b1;
    @(posedge clk_1);
    #1;
    cnt_clr = 1'b0;
    push_a();
    start_a = 1'b1;
    wait_valid(1'b0, lat);
    check("latency_single", 64'(lat), 64'd19);
    check("latch_cycles", 64'(n_latch), 64'd2);
    check("clk_pulses", 64'(n_pulse), 64'd8);
    repeat (3) @(posedge clk_1);
    #1;

    // start while busy is ignored
    nv0 = n_valid_a;
    push_a();
    start_a = 1'b1;
    @(posedge clk_1);
    #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk_1);
    #1;
    check("busy_at_5", 64'(busy_a), 64'd1);
    start_a = 1'b1;
    @(posedge clk_1);
    #1;
    start_a = 1'b0;
    wait_valid(1'b0, lat);
    check("latency_restart", 64'(lat), 64'd13);
    repeat (40) @(posedge clk_1);
    #1;
    check("valid_count_busy_start", 64'(n_valid_a - nv0), 64'd1);
    check("idle_after_busy_start", 64'(busy_a), 64'd0);

    // Auto polling with a button change between polls
    push_a();
    pat_a[0] = 8'hFF;
    push_a();
    push_a();
    push_a();
    pat_a[0] = 8'b1111_1110;
    nv0 = n_valid_a;
    auto_a = 1'b1;
    wait_valid(1'b0, lat);
    check("auto_first", 64'(lat), 64'd19);
    pat_a[0] = 8'hFF;
    wait_valid(1'b0, lat);
    check("auto_period_1", 64'(lat), 64'd20);
    wait_valid(1'b0, lat);
    check("auto_period_2", 64'(lat), 64'd20);
    repeat (5) @(posedge clk_1);
    #1;
    auto_a = 1'b0;
    wait_valid(1'b0, lat);
    check("auto_last", 64'(lat), 64'd15);
    repeat (50) @(posedge clk_1);
    #1;
    check("auto_valid_count", 64'(n_valid_a - nv0), 64'd4);
    check("auto_stop_idle", 64'(busy_a), 64'd0);

    // Reset during shift bit 4 aborts the poll
    nv0 = n_valid_a;
    start_a = 1'b1;
    @(posedge clk_1);
    #1;
    start_a = 1'b0;
    repeat (10) @(posedge clk_1);
    #1;
    check("busy_mid_shift", 64'(busy_a), 64'd1);
    rst = 1'b1;
    @(posedge clk_1);
    #1;
    rst = 1'b0;
    prev_a = '0;
    check_zero_a("abort");
    repeat (30) @(posedge clk_1);
    #1;
    check("abort_no_valid", 64'(n_valid_a - nv0), 64'd0);
    pat_a[0] = 8'h5A;
    pat_a[1] = 8'hC3;
    push_a();
    start_a = 1'b1;
    wait_valid(1'b0, lat);
    check("latency_after_abort", 64'(lat), 64'd19);

    // Wide, slow configuration
    push_b();
    start_b = 1'b1;
    wait_valid(1'b1, lat);
    check("latency_wide", 64'(lat), 64'd103);
    repeat (5) @(posedge clk_1);
    #1;
    check("busy_b_idle", 64'(busy_b), 64'd0);

    check("queue_a_drained", 64'(q_a.size()), 64'd0);
    check("queue_b_drained", 64'(q_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controller_poller_m.md
CONTROLLER_POLLER_M -- requirements
Module: controller_poller_m

Interface
- REQ-001: Parameter NUM_CONTROLLERS, default 2, is the number of serial controller ports, range 1..8.
- REQ-002: Parameter NUM_BUTTONS, default 8, is the bits shifted per controller per poll, range 1..16. 8 is NES-style; 16 is SNES-style.
- REQ-003: Parameter CLK_DIV, default 1, is the clk_1 cycles per controller_clk half-period, range 1..255.
- REQ-004: `clk_1  input  1` is the single clock. All logic is rising-edge.
- REQ-005: `rst  input  1` is the synchronous, active-high reset.
- REQ-006: `start  input  1` requests one poll and is sampled only in IDLE.
- REQ-007: `auto_en  input  1` enables continuous back-to-back polling.
- REQ-008: `controller_clk  output  1` is the shared shift clock to all controllers.
- REQ-009: `controller_latch  output  1` is the shared parallel-load strobe to all controllers.
- REQ-010: `controller_data_B  input  NUM_CONTROLLERS` carries per-controller serial data, active-low (0 = pressed).
- REQ-011: `buttons_out  output  NUM_CONTROLLERS*NUM_BUTTONS` holds the last completed poll, active-high.
- REQ-012: `pressed_out  output  NUM_CONTROLLERS*NUM_BUTTONS` holds the per-button 0->1 transitions of the last completed poll.
- REQ-013: `busy  output  1` is high whenever the state is not IDLE.
- REQ-014: `valid  output  1` is a one-cycle pulse on the cycle buttons_out updates.

Function
- REQ-015: The FSM has exactly four states: IDLE, LATCH, SHIFT, DONE.
- REQ-016: IDLE -> LATCH when start=1 or auto_en=1. Otherwise the FSM remains in IDLE.
- REQ-017: LATCH drives controller_latch=1 and controller_clk=0 for 2*CLK_DIV cycles, then transitions to SHIFT.
- REQ-018: SHIFT runs NUM_BUTTONS bit periods. Each bit period is CLK_DIV cycles with controller_clk=0, then CLK_DIV cycles with controller_clk=1.
- REQ-019: controller_data_B is sampled on the last clk_1 cycle of each low phase, before the controller_clk rising edge.
- REQ-020: After the high phase of bit NUM_BUTTONS-1, the FSM enters DONE for exactly 1 cycle and then returns to IDLE.
- REQ-021: Bit k (k=0 is the first bit sampled) of controller c is written to buttons_out[c*NUM_BUTTONS+k] as the inverse of the sampled data.
- REQ-022: In DONE, buttons_out and pressed_out update together and valid=1. valid=0 in all other cycles.
- REQ-023: pressed_out = new_buttons & ~old_buttons, evaluated in DONE. pressed_out holds until the next DONE.
- REQ-024: Latency from the start-sampling edge to valid high is exactly 2*CLK_DIV*(NUM_BUTTONS+1)+1 cycles. For defaults this is 19.
- REQ-025: start or auto_en asserted while busy=1 is ignored and is not queued.
- REQ-026: With auto_en held at 1, consecutive valid pulses are exactly 2*CLK_DIV*(NUM_BUTTONS+1)+2 cycles apart, including 1 IDLE cycle.
- REQ-027: Deasserting auto_en mid-poll completes the current poll and then stays in IDLE.
- REQ-028: The bit counter and divider counter are sized to their ranges, and the divider terminal count is CLK_DIV-1.
- REQ-029: controller_latch and controller_clk are registered outputs with no glitches.

Reset
- REQ-030: rst=1 forces state IDLE, and busy=0, valid=0, controller_clk=0, controller_latch=0.
- REQ-031: rst=1 clears buttons_out, pressed_out and the shift registers to 0.
- REQ-032: rst asserted mid-LATCH or mid-SHIFT aborts the poll with no valid pulse. Outputs take their reset values on the next edge.

Configuration
- REQ-033: Macro CONTROLLER_POLLER_EDGE_DETECT_EN, when defined, implements pressed_out per REQ-023.
- REQ-034: When CONTROLLER_POLLER_EDGE_DETECT_EN is undefined, pressed_out is constant 0 and no edge-detect registers are synthesised. All other behaviour is unchanged.

Verification
- REQ-035: Defaults, with controller 1 holding 8'b11111110 and controller 2 holding 8'b01111111, pulse start for 1 cycle. Required: valid 19 cycles later, buttons_out = 16'h7FFE, latch high 2 cycles, 8 controller_clk pulses.
- REQ-036: auto_en=1 with the same buttons, then change controller 1 to 8'b11111111 between polls. Required: valid every 20 cycles, pressed_out[0]=1 on the next poll only, and 0 on the poll after.
- REQ-037: NUM_BUTTONS=16, CLK_DIV=3, NUM_CONTROLLERS=4, distinct 16-bit patterns per controller. Required: valid after 103 cycles and all four fields correct.
- REQ-038: Assert rst for 1 cycle during SHIFT bit 4. Required: no valid, outputs zero, busy=0, and a new start polls correctly.
- REQ-039: Pulse start again while busy, at cycle 5 of a poll. Required: exactly one valid and no second poll.
- REQ-040: Build without CONTROLLER_POLLER_EDGE_DETECT_EN and repeat REQ-036. Required: pressed_out always 0, buttons_out identical to the run with the macro defined.
